// File: rtl/pipo_fifo.sv
// First-word-fall-through FIFO: head word is visible on out whenever out_vld is high.
// Optional synchronous flush input clr is built when PIPO_FIFO_CLR_EN is defined.
module pipo_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in,
  input  logic                     ld,
  output logic                     ld_rdy,
  input  logic                     rd,
  output logic [WIDTH-1:0]         out,
  output logic                     out_vld,
  output logic [$clog2(DEPTH):0]   count
`ifdef PIPO_FIFO_CLR_EN
  ,
  input  logic                     clr
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;
  logic             flush;

`ifdef PIPO_FIFO_CLR_EN
  assign flush = clr;
`else
  assign flush = 1'b0;
`endif

  // Handshake flags and head word come straight from registered pointer/count state.
  always_comb begin
    out_vld = (count != '0);
    ld_rdy  = (count != FULL);
    wr_en   = ld && ld_rdy && !flush;
    rd_en   = rd && out_vld && !flush;
    out     = out_vld ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in;
  end

endmodule
